// File: rtl/seq_arith_pkg.sv
// Shared constants for the sequential arithmetic datapath (adder and divider).
// Holds the FSM state encoding and the default operand width.
package seq_arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: trial subtract of d from {r, q_msb}, zero latency.
// Purely combinational, so there is no handshake and no backpressure.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_r,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    always_comb begin
        trial = {r, q_msb} - {1'b0, d};
        // A set top bit is the borrow: d did not fit, so keep the shifted remainder
        q_bit = ~trial[WIDTH];
        if (trial[WIDTH]) begin
            next_r = {r[WIDTH-2:0], q_msb};
        end else begin
            next_r = trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider; WIDTH+1 edges start-to-done (1 edge when dividing by zero).
// start is only sampled in IDLE; starts while busy are dropped, not queued.
module seq_divider
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_r;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .r      (r_q),
        .q_msb  (qreg_q[WIDTH-1]),
        .d      (d_q),
        .next_r (step_r),
        .q_bit  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qreg_d  = qreg_q;
        r_d     = r_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    qreg_d = dividend;
                    d_d    = divisor;
                    r_d    = '0;
                    cnt_d  = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        zero_d  = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                qreg_d = {qreg_q[WIDTH-2:0], step_bit};
                r_d    = step_r;
                // Results are registered on the edge entering DONE so they are valid with done
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quo_d   = qreg_d;
                    rem_d   = step_r;
                    dz_d    = 1'b0;
                    zero_d  = (qreg_d == '0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qreg_q  <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qreg_q  <= qreg_d;
            r_q     <= r_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         z;
        int           lat;
        int           issue;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         zero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   accepted = 0;
    logic prev_done = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still %0d after 40 cycles, expected 0", name, busy);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic ez, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.z = ez; e.lat = lat; e.issue = cyc;
            sb.push_back(e);
            accepted++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic ez, input int lat);
        issue(a, b, eq, er, edz, ez, lat, 1'b1);
        wait_idle("run");
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, W + 1);
        run(8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 1'b1, W + 1);
        run(8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 1'b1, W + 1);
        run(8'd255, 8'd0,   8'd255, 8'd255, 1'b1, 1'b0, 1);
        run(8'd17,  8'd17,  8'd1,   8'd0,   1'b0, 1'b0, W + 1);
        run(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 1'b1, W + 1);

        // Starts during CALC and during the DONE cycle must both be dropped
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, W + 1, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen_255_1", 32'(seen), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_after_ignored", 32'(busy), 32'd0);
        chk("held_quotient", 32'(quotient), 32'd255);
        chk("held_remainder", 32'(remainder), 32'd0);

        // Abort 200/9 on its fourth CALC cycle
        issue(8'd200, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 1'b0, W + 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("done_pulse_count", 32'(done_cnt), 32'(accepted));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
